phase_monitor: RTL and testbench

PHASE_MONITOR -- requirements
Module: phase_monitor

---
 rtl/phase_monitor.sv | 105 ++++++++++
 tb/tb_phase_monitor.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_monitor.sv
// Phase-sequence lock monitor: tracks a 0->1->2 phase rotation, reports lock, wraps and errors.
// Optional PHASE_ERRCNT_EN adds the err_cnt port with a saturating error counter.
module phase_monitor #(
    parameter int LOCK_CNT = 3,
    parameter int CYC_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       phase,
    input  logic             clr,
    output logic [2:0]       onehot,
    output logic             locked,
    output logic             wrap,
    output logic             err,
    output logic [CYC_W-1:0] cyc_cnt
`ifdef PHASE_ERRCNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    localparam logic [0:0] HUNT   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    localparam logic [3:0] RUN_LAST = 4'(LOCK_CNT - 1);

    logic [0:0] state;
    logic [3:0] run;
    logic [1:0] prev;
    logic       prev_vld;
    logic [1:0] nxt;
    logic       legal;

    assign nxt    = (prev == 2'd2) ? 2'd0 : prev + 2'd1;
    assign legal  = prev_vld && (prev != 2'd3) && (phase == nxt);
    assign locked = (state == LOCKED);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev     <= 2'd0;
            prev_vld <= 1'b0;
            onehot   <= 3'b000;
        end else begin
            prev     <= phase;
            prev_vld <= 1'b1;
            onehot   <= (phase == 2'd3) ? 3'b000 : (3'b001 << phase);
        end
    end

    // No legality check until prev holds a real sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= HUNT;
            run   <= 4'd0;
            wrap  <= 1'b0;
            err   <= 1'b0;
        end else begin
            wrap <= 1'b0;
            err  <= 1'b0;
            if (prev_vld) begin
                if (state == HUNT) begin
                    if (!legal) begin
                        run <= 4'd0;
                    end else if (run == RUN_LAST) begin
                        state <= LOCKED;
                        run   <= 4'd0;
                    end else begin
                        run <= run + 4'd1;
                    end
                end else begin
                    if (!legal) begin
                        state <= HUNT;
                        run   <= 4'd0;
                        err   <= 1'b1;
                    end else if (prev == 2'd2) begin
                        wrap <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt <= '0;
        end else if (clr) begin
            cyc_cnt <= '0;
        end else if (wrap && (cyc_cnt != '1)) begin
            cyc_cnt <= cyc_cnt + 1'b1;
        end
    end

`ifdef PHASE_ERRCNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= 8'd0;
        end else if (clr) begin
            err_cnt <= 8'd0;
        end else if (err && (err_cnt != 8'hff)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_phase_monitor.sv
// Scoreboard bench for phase_monitor: two instances (CYC_W=8 and CYC_W=2)
// driven from the same stimulus and checked against a behavioural model.
module tb_phase_monitor;

    logic       clk;
    logic       rst;
    logic [1:0] phase;
    logic       clr;

    logic [2:0] oh0, oh1;
    logic       lk0, lk1, wr0, wr1, er0, er1;
    logic [7:0] cc0;
    logic [1:0] cc1;
`ifdef PHASE_ERRCNT_EN
    logic [7:0] ec0, ec1;
`endif

    phase_monitor #(.LOCK_CNT(3), .CYC_W(8)) u0 (
        .clk(clk), .rst(rst), .phase(phase), .clr(clr),
        .onehot(oh0), .locked(lk0), .wrap(wr0), .err(er0),
        .cyc_cnt(cc0)
`ifdef PHASE_ERRCNT_EN
        , .err_cnt(ec0)
`endif
    );

    phase_monitor #(.LOCK_CNT(3), .CYC_W(2)) u1 (
        .clk(clk), .rst(rst), .phase(phase), .clr(clr),
        .onehot(oh1), .locked(lk1), .wrap(wr1), .err(er1),
        .cyc_cnt(cc1)
`ifdef PHASE_ERRCNT_EN
        , .err_cnt(ec1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] oh;
        logic       lk;
        logic       wr;
        logic       er;
        int         c0;
        int         c1;
        int         ec;
    } exp_t;

    exp_t sb[$];

    int n_run;
    int n_fail;

    // model state
    int   m_prev;
    bit   m_vld;
    bit   m_lock;
    int   m_run;
    bit   m_wrap;
    bit   m_err;
    int   m_c0;
    int   m_c1;
    int   m_ec;
    logic [2:0] m_oh;
    int   cur;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_prev = 0; m_vld = 0; m_lock = 0; m_run = 0;
        m_wrap = 0; m_err = 0; m_c0 = 0; m_c1 = 0; m_ec = 0;
        m_oh = 3'b000;
    endtask

    task automatic m_tick(input int ph, input bit c);
        bit lg;
        bit nw;
        bit ne;
        int want;
        want = (m_prev + 1) % 3;
        lg = m_vld && (m_prev != 3) && (ph == want);
        nw = 0;
        ne = 0;
        if (c) begin
            m_c0 = 0; m_c1 = 0; m_ec = 0;
        end else begin
            if (m_wrap && m_c0 < 255) m_c0++;
            if (m_wrap && m_c1 < 3) m_c1++;
            if (m_err && m_ec < 255) m_ec++;
        end
        if (m_vld) begin
            if (!m_lock) begin
                if (!lg) m_run = 0;
                else if (m_run == 2) begin m_lock = 1; m_run = 0; end
                else m_run++;
            end else if (!lg) begin
                m_lock = 0; m_run = 0; ne = 1;
            end else if (m_prev == 2) begin
                nw = 1;
            end
        end
        m_prev = ph;
        m_vld = 1;
        case (ph)
            0: m_oh = 3'b001;
            1: m_oh = 3'b010;
            2: m_oh = 3'b100;
            default: m_oh = 3'b000;
        endcase
        m_wrap = nw;
        m_err = ne;
    endtask

    task automatic step(input int ph, input bit c);
        exp_t e;
        phase = 2'(ph);
        clr = c;
        m_tick(ph, c);
        e.oh = m_oh; e.lk = m_lock; e.wr = m_wrap; e.er = m_err;
        e.c0 = m_c0; e.c1 = m_c1; e.ec = m_ec;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("onehot0", 32'(oh0), 32'(e.oh));
        chk("onehot1", 32'(oh1), 32'(e.oh));
        chk("locked0", 32'(lk0), 32'(e.lk));
        chk("locked1", 32'(lk1), 32'(e.lk));
        chk("wrap0", 32'(wr0), 32'(e.wr));
        chk("wrap1", 32'(wr1), 32'(e.wr));
        chk("err0", 32'(er0), 32'(e.er));
        chk("err1", 32'(er1), 32'(e.er));
        chk("cyc0", 32'(cc0), 32'(e.c0));
        chk("cyc1", 32'(cc1), 32'(e.c1));
        chk("excl", 32'(wr0 & er0), 32'd0);
`ifdef PHASE_ERRCNT_EN
        chk("ecnt0", 32'(ec0), 32'(e.ec));
        chk("ecnt1", 32'(ec1), 32'(e.ec));
`endif
        cur = ph;
    endtask

    task automatic adv(input int n);
        for (int i = 0; i < n; i++) step((cur + 1) % 3, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_oh"}, 32'(oh0), 32'd0);
        chk({tag, "_lk"}, 32'(lk0 | lk1), 32'd0);
        chk({tag, "_wr"}, 32'(wr0 | wr1), 32'd0);
        chk({tag, "_er"}, 32'(er0 | er1), 32'd0);
        chk({tag, "_cc0"}, 32'(cc0), 32'd0);
        chk({tag, "_cc1"}, 32'(cc1), 32'd0);
`ifdef PHASE_ERRCNT_EN
        chk({tag, "_ec"}, 32'(ec0), 32'd0);
`endif
    endtask

    initial begin
        n_run = 0;
        n_fail = 0;
        rst = 1'b0;
        phase = 2'd0;
        clr = 1'b0;
        cur = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst");
        rst = 1'b1;

        // lock on the 4th sample, first wrap after the next 2->0
        step(0, 1'b0);
        step(1, 1'b0);
        step(2, 1'b0);
        chk("nolock3", 32'(lk0), 32'd0);
        step(0, 1'b0);
        chk("lock4", 32'(lk0), 32'd1);
        chk("nowrap_lock", 32'(wr0), 32'd0);
        adv(3);
        chk("wrap1st", 32'(wr0), 32'd1);
        step(1, 1'b0);
        chk("cyc_one", 32'(cc0), 32'd1);

        // hold phase at 1 an extra cycle
        step(1, 1'b0);
        chk("hold_err", 32'(er0), 32'd1);
        chk("hold_unlk", 32'(lk0), 32'd0);
        chk("hold_cyc", 32'(cc0), 32'd1);
        adv(2);
        chk("relock_no", 32'(lk0), 32'd0);
        adv(1);
        chk("relock", 32'(lk0), 32'd1);

        // phase 3 while hunting after two legal transitions
        step(1, 1'b0);
        step(1, 1'b0);
        step(2, 1'b0);
        step(0, 1'b0);
        step(3, 1'b0);
        chk("ph3_noerr", 32'(er0), 32'd0);
        step(0, 1'b0);
        adv(2);
        chk("ph3_hunt", 32'(lk0), 32'd0);
        adv(1);
        chk("ph3_lock", 32'(lk0), 32'd1);

        // saturate the narrow counter, then clear on a wrap cycle
        step(0, 1'b1);
        while (cur != 2) adv(1);
        for (int k = 0; k < 5; k++) adv(3);
        chk("sat_cc1", 32'(cc1), 32'd3);
        while (wr0 !== 1'b1) adv(1);
        step((cur + 1) % 3, 1'b1);
        chk("clr_cc0", 32'(cc0), 32'd0);
        chk("clr_cc1", 32'(cc1), 32'd0);

        // mostly-legal random stream with occasional clr
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 15);
            if (r == 0) step(3, 1'b0);
            else if (r == 1) step(cur, 1'b0);
            else step((cur + 1) % 3, ($urandom_range(0, 40) == 0));
        end

        // async reset mid-lock
        while (lk0 !== 1'b1) adv(1);
        #2;
        rst = 1'b0;
        m_reset();
        #1;
        chk_zero("midrst");
        @(negedge clk);
        rst = 1'b1;
        step(2, 1'b0);
        step(1, 1'b0);
        chk("post_rst_err", 32'(er0), 32'd1 - 32'd1);
        step(2, 1'b0);
        step(0, 1'b0);
        adv(1);
        chk("post_rst_lk", 32'(lk0), 32'd1);

`ifdef PHASE_ERRCNT_EN
        for (int k = 0; k < 300; k++) begin
            while (lk0 !== 1'b1) adv(1);
            step(cur, 1'b0);
        end
        adv(1);
        chk("ecnt_sat", 32'(ec0), 32'd255);
        step((cur + 1) % 3, 1'b1);
        chk("ecnt_clr", 32'(ec0), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
